// File: rtl/packet_switch_4port.sv
// packet_switch_4port: four-port single-beat packet switch. Each input owns a
// small FIFO whose head carries a pending-output mask; each output runs its own
// round-robin arbiter over the heads that still owe it a copy.
module packet_switch_4port #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid_in,
    input  logic [3:0]        p0_source_in,
    input  logic [3:0]        p0_target_in,
    input  logic [DATA_W-1:0] p0_data_in,
    output logic              p0_ready_out,
    output logic              p0_valid_out,
    output logic [3:0]        p0_source_out,
    output logic [3:0]        p0_target_out,
    output logic [DATA_W-1:0] p0_data_out,
    input  logic              p1_valid_in,
    input  logic [3:0]        p1_source_in,
    input  logic [3:0]        p1_target_in,
    input  logic [DATA_W-1:0] p1_data_in,
    output logic              p1_ready_out,
    output logic              p1_valid_out,
    output logic [3:0]        p1_source_out,
    output logic [3:0]        p1_target_out,
    output logic [DATA_W-1:0] p1_data_out,
    input  logic              p2_valid_in,
    input  logic [3:0]        p2_source_in,
    input  logic [3:0]        p2_target_in,
    input  logic [DATA_W-1:0] p2_data_in,
    output logic              p2_ready_out,
    output logic              p2_valid_out,
    output logic [3:0]        p2_source_out,
    output logic [3:0]        p2_target_out,
    output logic [DATA_W-1:0] p2_data_out,
    input  logic              p3_valid_in,
    input  logic [3:0]        p3_source_in,
    input  logic [3:0]        p3_target_in,
    input  logic [DATA_W-1:0] p3_data_in,
    output logic              p3_ready_out,
    output logic              p3_valid_out,
    output logic [3:0]        p3_source_out,
    output logic [3:0]        p3_target_out,
    output logic [DATA_W-1:0] p3_data_out
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PTRW = AW + 1;
    localparam int PW   = 8 + DATA_W;

    logic [3:0]        in_valid;
    logic [3:0]        in_source   [4];
    logic [3:0]        in_target   [4];
    logic [DATA_W-1:0] in_data     [4];
    logic [3:0]        ready_vec;
    logic [3:0]        head_source [4];
    logic [3:0]        head_target [4];
    logic [DATA_W-1:0] head_data   [4];
    logic [3:0]        pending     [4];   // [input][output]: head still owes this output
    logic [3:0]        grant       [4];   // [output][input]: one-hot grant
    logic [3:0]        out_valid;
    logic [3:0]        out_source  [4];
    logic [3:0]        out_target  [4];
    logic [DATA_W-1:0] out_data    [4];

    assign in_valid     = {p3_valid_in, p2_valid_in, p1_valid_in, p0_valid_in};
    assign in_source[0] = p0_source_in;
    assign in_source[1] = p1_source_in;
    assign in_source[2] = p2_source_in;
    assign in_source[3] = p3_source_in;
    assign in_target[0] = p0_target_in;
    assign in_target[1] = p1_target_in;
    assign in_target[2] = p2_target_in;
    assign in_target[3] = p3_target_in;
    assign in_data[0]   = p0_data_in;
    assign in_data[1]   = p1_data_in;
    assign in_data[2]   = p2_data_in;
    assign in_data[3]   = p3_data_in;

    genvar gi;

    // Per-input queue: pointers carry an extra wrap bit so full and empty differ.
    for (gi = 0; gi < 4; gi++) begin : g_in
        logic [PW-1:0]   mem [FIFO_DEPTH];
        logic [PTRW-1:0] wr_q, rd_q, wr_d, rd_d;
        logic [3:0]      served_q, served_d;
        logic [3:0]      gnt_l;
        logic            ready_q, ready_d;
        logic            legal, push, pop, empty;
        logic [PW-1:0]   head;

        assign legal = (in_source[gi] == 4'(1 << gi)) && (in_target[gi] != 4'b0) &&
                       ((in_target[gi] & in_source[gi]) == 4'b0);
        assign push  = in_valid[gi] & ready_q & legal;
        assign empty = (wr_q == rd_q);
        assign head  = mem[rd_q[AW-1:0]];

        assign head_source[gi] = head[PW-1 -: 4];
        assign head_target[gi] = head[PW-5 -: 4];
        assign head_data[gi]   = head[DATA_W-1:0];
        // Outputs already served by this head are masked off the original target.
        assign pending[gi]     = empty ? 4'b0 : (head[PW-5 -: 4] & ~served_q);

        // Gather the grants every output gave to this input.
        always_comb begin
            gnt_l = '0;
            for (int m = 0; m < 4; m++) gnt_l[m] = grant[m][gi];
        end

        // The head leaves once its last outstanding output has been granted.
        assign pop      = !empty && ((pending[gi] & ~gnt_l) == 4'b0);
        assign wr_d     = wr_q + PTRW'(push);
        assign rd_d     = rd_q + PTRW'(pop);
        assign served_d = pop ? 4'b0 : (served_q | gnt_l);
        assign ready_d  = !((wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]));
        assign ready_vec[gi] = ready_q;

        // Payload storage; validity is defined by the pointers, so no reset.
        always_ff @(posedge clk) begin
            if (push) mem[wr_q[AW-1:0]] <= {in_source[gi], in_target[gi], in_data[gi]};
        end

        // Queue pointers, served mask and registered ready flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_q     <= '0;
                rd_q     <= '0;
                served_q <= '0;
                ready_q  <= 1'b0;
            end else begin
                wr_q     <= wr_d;
                rd_q     <= rd_d;
                served_q <= served_d;
                ready_q  <= ready_d;
            end
        end
    end

    // Per-output round-robin arbiter with registered packet outputs.
    for (gi = 0; gi < 4; gi++) begin : g_out
        logic [1:0]        rr_q;
        logic [3:0]        cand, gnt;
        logic [1:0]        gnt_idx, idx;
        logic              found;
        logic              valid_q;
        logic [3:0]        source_q, target_q;
        logic [DATA_W-1:0] data_q;

        // Pick the first candidate at or after rr_q, wrapping 3 -> 0.
        always_comb begin
            cand    = '0;
            gnt     = '0;
            gnt_idx = rr_q;
            idx     = rr_q;
            found   = 1'b0;
            for (int k = 0; k < 4; k++) cand[k] = pending[k][gi];
            for (int k = 0; k < 4; k++) begin
                idx = rr_q + 2'(k);
                if (!found && cand[idx]) begin
                    found        = 1'b1;
                    gnt[idx]     = 1'b1;
                    gnt_idx      = idx;
                end
            end
        end

        assign grant[gi] = gnt;

        // Register the granted head; idle cycles drive zeros on every field.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_q     <= '0;
                valid_q  <= 1'b0;
                source_q <= '0;
                target_q <= '0;
                data_q   <= '0;
            end else begin
                valid_q <= found;
                if (found) begin
                    rr_q     <= gnt_idx + 2'd1;
                    source_q <= head_source[gnt_idx];
                    target_q <= head_target[gnt_idx];
                    data_q   <= head_data[gnt_idx];
                end else begin
                    source_q <= '0;
                    target_q <= '0;
                    data_q   <= '0;
                end
            end
        end

        assign out_valid[gi]  = valid_q;
        assign out_source[gi] = source_q;
        assign out_target[gi] = target_q;
        assign out_data[gi]   = data_q;
    end

    assign p0_ready_out  = ready_vec[0];
    assign p1_ready_out  = ready_vec[1];
    assign p2_ready_out  = ready_vec[2];
    assign p3_ready_out  = ready_vec[3];
    assign p0_valid_out  = out_valid[0];
    assign p1_valid_out  = out_valid[1];
    assign p2_valid_out  = out_valid[2];
    assign p3_valid_out  = out_valid[3];
    assign p0_source_out = out_source[0];
    assign p1_source_out = out_source[1];
    assign p2_source_out = out_source[2];
    assign p3_source_out = out_source[3];
    assign p0_target_out = out_target[0];
    assign p1_target_out = out_target[1];
    assign p2_target_out = out_target[2];
    assign p3_target_out = out_target[3];
    assign p0_data_out   = out_data[0];
    assign p1_data_out   = out_data[1];
    assign p2_data_out   = out_data[2];
    assign p3_data_out   = out_data[3];

endmodule

// File: tb/tb_packet_switch_4port.sv
// tb_packet_switch_4port: scenario tasks with inline checks plus a per
// (output, source) scoreboard filled on accepted packets and drained by a monitor.
module tb_packet_switch_4port;
    localparam int DW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [3:0]    vi;
    logic [3:0]    si [4];
    logic [3:0]    ti [4];
    logic [DW-1:0] di [4];
    logic [3:0]    rdy;
    logic [3:0]    vo;
    logic [3:0]    so [4];
    logic [3:0]    to [4];
    logic [DW-1:0] dout [4];

    int n_tests = 0;
    int n_fail  = 0;

    // Expected packets {src, tgt, data}, indexed by output*4 + source.
    logic [15:0] exp_q [16][$];
    int          mon_s;
    logic [15:0] mon_e;

    always #5 clk = ~clk;

    packet_switch_4port #(.FIFO_DEPTH(4), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid_in(vi[0]), .p0_source_in(si[0]), .p0_target_in(ti[0]), .p0_data_in(di[0]),
        .p0_ready_out(rdy[0]), .p0_valid_out(vo[0]), .p0_source_out(so[0]),
        .p0_target_out(to[0]), .p0_data_out(dout[0]),
        .p1_valid_in(vi[1]), .p1_source_in(si[1]), .p1_target_in(ti[1]), .p1_data_in(di[1]),
        .p1_ready_out(rdy[1]), .p1_valid_out(vo[1]), .p1_source_out(so[1]),
        .p1_target_out(to[1]), .p1_data_out(dout[1]),
        .p2_valid_in(vi[2]), .p2_source_in(si[2]), .p2_target_in(ti[2]), .p2_data_in(di[2]),
        .p2_ready_out(rdy[2]), .p2_valid_out(vo[2]), .p2_source_out(so[2]),
        .p2_target_out(to[2]), .p2_data_out(dout[2]),
        .p3_valid_in(vi[3]), .p3_source_in(si[3]), .p3_target_in(ti[3]), .p3_data_in(di[3]),
        .p3_ready_out(rdy[3]), .p3_valid_out(vo[3]), .p3_source_out(so[3]),
        .p3_target_out(to[3]), .p3_data_out(dout[3])
    );

    // Scoreboard fill: a legal packet offered while ready is accepted at this edge.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 4; p++) begin
                if (vi[p] && rdy[p] && si[p] == 4'(1 << p) && ti[p] != 4'b0 && (ti[p] & si[p]) == 4'b0) begin
                    for (int m = 0; m < 4; m++)
                        if (ti[p][m]) exp_q[m*4 + p].push_back({si[p], ti[p], di[p]});
                end
            end
        end
    end

    // Reset discards every in-flight packet.
    always @(negedge rst_n) begin
        for (int i = 0; i < 16; i++) exp_q[i].delete();
    end

    // Monitor: every emitted packet must be the oldest expected one from its source.
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            n_tests++;
            if (vo[m]) begin
                mon_s = -1;
                for (int k = 0; k < 4; k++) if (so[m] == 4'(1 << k)) mon_s = k;
                $display("[TB] out p%0d src=%b tgt=%b data=%h", m, so[m], to[m], dout[m]);
                if (mon_s < 0 || exp_q[m*4 + mon_s].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out p%0d: got src=%b tgt=%b data=%h, expected no packet",
                             m, so[m], to[m], dout[m]);
                end else begin
                    mon_e = exp_q[m*4 + mon_s].pop_front();
                    if ({so[m], to[m], dout[m]} !== mon_e) begin
                        n_fail++;
                        $display("FAIL packet_out p%0d: got %h expected %h", m, {so[m], to[m], dout[m]}, mon_e);
                    end
                end
            end else if (so[m] !== 4'b0 || to[m] !== 4'b0 || dout[m] !== '0) begin
                n_fail++;
                $display("FAIL idle_fields p%0d: got src=%b tgt=%b data=%h expected zeros", m, so[m], to[m], dout[m]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        vi = '0;
        for (int p = 0; p < 4; p++) begin
            si[p] = '0; ti[p] = '0; di[p] = '0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (rdy !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", rdy); end
        n_tests++; if (vo !== 4'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", vo); end
        n_tests++; if (dout[3] !== '0 || so[1] !== 4'b0 || to[2] !== 4'b0) begin
            n_fail++; $display("FAIL reset_fields: got data3=%h src1=%b tgt2=%b expected 0", dout[3], so[1], to[2]);
        end
        repeat (2) @(negedge clk);
        n_tests++; if (rdy !== 4'b0) begin n_fail++; $display("FAIL reset_hold_ready: got %b expected 0000", rdy); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (rdy !== 4'hF) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1111", rdy); end
    endtask

    task automatic test_unicast();
        @(negedge clk);
        vi[0] = 1'b1; si[0] = 4'b0001; ti[0] = 4'b0100; di[0] = 8'hA5;
        @(negedge clk);
        idle_inputs();
        n_tests++; if (vo !== 4'b0) begin n_fail++; $display("FAIL uni_latency: got %b expected 0000", vo); end
        @(negedge clk);
        n_tests++; if (vo !== 4'b0100) begin n_fail++; $display("FAIL uni_valid: got %b expected 0100", vo); end
        n_tests++; if ({so[2], to[2], dout[2]} !== 16'h14A5) begin
            n_fail++; $display("FAIL uni_fields: got %h expected 14a5", {so[2], to[2], dout[2]});
        end
        @(negedge clk);
        n_tests++; if (vo !== 4'b0) begin n_fail++; $display("FAIL uni_once: got %b expected 0000", vo); end
    endtask

    task automatic test_broadcast();
        @(negedge clk);
        vi[1] = 1'b1; si[1] = 4'b0010; ti[1] = 4'b1101; di[1] = 8'h3C;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        n_tests++; if (vo !== 4'b1101) begin n_fail++; $display("FAIL bc_valid: got %b expected 1101", vo); end
        n_tests++; if (dout[0] !== 8'h3C || dout[2] !== 8'h3C || dout[3] !== 8'h3C) begin
            n_fail++; $display("FAIL bc_data: got %h/%h/%h expected 3c", dout[0], dout[2], dout[3]);
        end
        n_tests++; if (so[3] !== 4'b0010 || to[0] !== 4'b1101) begin
            n_fail++; $display("FAIL bc_hdr: got src=%b tgt=%b expected 0010/1101", so[3], to[0]);
        end
        @(negedge clk);
        n_tests++; if (vo !== 4'b0) begin n_fail++; $display("FAIL bc_once: got %b expected 0000", vo); end
        n_tests++; if (rdy !== 4'hF) begin n_fail++; $display("FAIL bc_ready: got %b expected 1111", rdy); end
    endtask

    task automatic test_illegal();
        logic [3:0] srcs [3];
        logic [3:0] tgts [3];
        srcs[0] = 4'b0100; tgts[0] = 4'b0100;
        srcs[1] = 4'b0001; tgts[1] = 4'b1000;
        srcs[2] = 4'b0100; tgts[2] = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vi[2] = 1'b1; si[2] = srcs[c]; ti[2] = tgts[c]; di[2] = 8'hE0 + 8'(c);
        end
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            n_tests++; if (vo !== 4'b0) begin n_fail++; $display("FAIL illegal_out c%0d: got %b expected 0000", c, vo); end
            n_tests++; if (rdy !== 4'hF) begin n_fail++; $display("FAIL illegal_ready c%0d: got %b expected 1111", c, rdy); end
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        vi[0] = 1'b1; si[0] = 4'b0001; ti[0] = 4'b1000; di[0] = 8'h11;
        vi[1] = 1'b1; si[1] = 4'b0010; ti[1] = 4'b1000; di[1] = 8'h22;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        n_tests++; if (vo[3] !== 1'b1 || dout[3] !== 8'h11) begin n_fail++; $display("FAIL cont_first: got v=%b d=%h expected 1/11", vo[3], dout[3]); end
        @(negedge clk);
        n_tests++; if (vo[3] !== 1'b1 || dout[3] !== 8'h22) begin n_fail++; $display("FAIL cont_second: got v=%b d=%h expected 1/22", vo[3], dout[3]); end
        @(negedge clk);
        n_tests++; if (vo !== 4'b0) begin n_fail++; $display("FAIL cont_idle: got %b expected 0000", vo); end
        // Pointer now sits at input 2, so input 2 must beat input 1.
        vi[1] = 1'b1; si[1] = 4'b0010; ti[1] = 4'b1000; di[1] = 8'h44;
        vi[2] = 1'b1; si[2] = 4'b0100; ti[2] = 4'b1000; di[2] = 8'h55;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        n_tests++; if (vo[3] !== 1'b1 || dout[3] !== 8'h55) begin n_fail++; $display("FAIL rr_first: got v=%b d=%h expected 1/55", vo[3], dout[3]); end
        @(negedge clk);
        n_tests++; if (vo[3] !== 1'b1 || dout[3] !== 8'h44) begin n_fail++; $display("FAIL rr_second: got v=%b d=%h expected 1/44", vo[3], dout[3]); end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (exp_q[i].size() != 0) begin n_fail++; $display("FAIL cont_missing q%0d: got %0d pending expected 0", i, exp_q[i].size()); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            if (c >= 2 && c <= 5) begin
                n_tests++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready c%0d: got %b expected 1", c, rdy[0]); end
            end
            if (c == 6) begin
                n_tests++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b expected 0", rdy[0]); end
            end
            if (c == 7) begin
                n_tests++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL bp_reopen: got %b expected 1", rdy[0]); end
            end
            vi = 4'b0110;
            si[1] = 4'b0010; ti[1] = 4'b1000; di[1] = 8'h80 + 8'(c);
            si[2] = 4'b0100; ti[2] = 4'b1000; di[2] = 8'hC0 + 8'(c);
            if (c >= 1 && c <= 5) begin
                vi[0] = 1'b1; si[0] = 4'b0001; ti[0] = 4'b1000; di[0] = 8'(c);
            end else begin
                vi[0] = 1'b0;
            end
            @(negedge clk);
        end
        idle_inputs();
        repeat (30) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (exp_q[i].size() != 0) begin n_fail++; $display("FAIL bp_missing q%0d: got %0d pending expected 0", i, exp_q[i].size()); end
        end
    endtask

    task automatic test_reset_midtraffic();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            vi = 4'b0111;
            si[0] = 4'b0001; ti[0] = 4'b1000; di[0] = 8'h60 + 8'(c);
            si[1] = 4'b0010; ti[1] = 4'b1100; di[1] = 8'h70 + 8'(c);
            si[2] = 4'b0100; ti[2] = 4'b1000; di[2] = 8'h90 + 8'(c);
            @(negedge clk);
        end
        idle_inputs();
        n_tests++; if (vo[3] !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", vo[3]); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (vo !== 4'b0) begin n_fail++; $display("FAIL mid_clear_valid: got %b expected 0000", vo); end
        n_tests++; if (dout[3] !== '0 || so[3] !== 4'b0 || to[2] !== 4'b0) begin
            n_fail++; $display("FAIL mid_clear_fields: got d=%h s=%b t=%b expected 0", dout[3], so[3], to[2]);
        end
        n_tests++; if (rdy !== 4'b0) begin n_fail++; $display("FAIL mid_clear_ready: got %b expected 0000", rdy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++; if (vo !== 4'b0) begin n_fail++; $display("FAIL mid_stale c%0d: got %b expected 0000", c, vo); end
            if (c == 0) begin
                n_tests++; if (rdy !== 4'hF) begin n_fail++; $display("FAIL mid_ready: got %b expected 1111", rdy); end
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_unicast();
        test_broadcast();
        test_illegal();
        test_contention();
        test_backpressure();
        test_reset_midtraffic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
